// File: rtl/shift_normalizer.sv
// Sequential normalizer: finds the left shift that removes leading zeros (logical)
// or redundant sign bits (arithmetic) by binary search, one step per cycle.
module shift_normalizer #(
  parameter  int WIDTH = 8,
  localparam int LOG2  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LOG2:0]    out_shift,
  output logic             out_zero
);
  localparam int SW = LOG2 + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [SW-1:0]   cnt, cnt_nxt;
  logic [LOG2-1:0] k, k_nxt;
  logic            mode, mode_nxt;
  logic            zero, zero_nxt;

  logic [SW-1:0]    step, span;
  logic [WIDTH-1:0] top_mask, top;
  logic             pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      k     <= '0;
      mode  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
      k     <= k_nxt;
      mode  <= mode_nxt;
      zero  <= zero_nxt;
    end
  end

  always_comb begin
    // Arithmetic mode looks one bit further: the MSB itself plus 2^k copies of it.
    step     = SW'(1) << k;
    span     = mode ? step + SW'(1) : step;
    top_mask = ~({WIDTH{1'b1}} >> span);
    top      = work & top_mask;
    pass     = (top == '0) || (mode && (top == top_mask));

    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    k_nxt     = k;
    mode_nxt  = mode;
    zero_nxt  = zero;

    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nxt  = in_data;
          mode_nxt  = in_arith;
          cnt_nxt   = '0;
          k_nxt     = LOG2'(LOG2 - 1);
          zero_nxt  = (in_data == '0);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (pass) begin
          work_nxt = work << step;
          cnt_nxt  = cnt + step;
        end
        if (k == '0) state_nxt = DONE;
        else         k_nxt     = k - LOG2'(1);
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out_data  = work;
  // The search tops out at WIDTH-1; only a logical all-zero word reports WIDTH.
  assign out_shift = (zero && !mode) ? SW'(WIDTH) : cnt;
  assign out_zero  = zero;
endmodule
